// File: rtl/stall_consumer_pkg.sv
// Shared package for the stall_consumer slice: request field widths,
// default queue geometry, the head-slot decode enum and a saturating adder.
package stall_consumer_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int ID_WIDTH      = 8;

  localparam int CONSUMER_DEPTH_DEFAULT = 4;
  localparam int CONSUMER_SVC_DEFAULT   = 3;

  // What the retire engine does with the head slot this cycle
  typedef enum logic [1:0] {
    HEAD_EMPTY  = 2'd0,
    HEAD_DROP   = 2'd1,
    HEAD_WAIT   = 2'd2,
    HEAD_RETIRE = 2'd3
  } head_action_e;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/stall_consumer_queue.sv
// consumer_queue: circular request buffer with per-slot valid bits.
// A slot stays occupied after its valid bit is cleared by a flush; the
// retire engine pops such slots silently.
module consumer_queue
  import stall_consumer_pkg::*;
#(
  parameter int DEPTH = CONSUMER_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ADDRESS_WIDTH-1:0] push_address,
  input  logic [ID_WIDTH-1:0]      push_id,
  input  logic                     push_valid,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [ID_WIDTH-1:0]      flush_id,
  output logic                     head_valid,
  output logic [ADDRESS_WIDTH-1:0] head_address,
  output logic [ID_WIDTH-1:0]      head_id,
  output logic                     head_flush_match,
  output logic [PTR_W:0]           flush_slot_count,
  output logic [PTR_W:0]           occupancy,
  output logic                     full
);

  logic [PTR_W:0]           head_q;
  logic [PTR_W:0]           tail_q;
  logic [PTR_W-1:0]         head_idx;
  logic [PTR_W-1:0]         tail_idx;
  logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
  logic [ID_WIDTH-1:0]      id_mem   [DEPTH];
  logic [DEPTH-1:0]         valid_q;
  logic [DEPTH-1:0]         valid_d;
  logic [DEPTH-1:0]         occupied;
  logic [DEPTH-1:0]         flush_match;

  assign head_idx         = head_q[PTR_W-1:0];
  assign tail_idx         = tail_q[PTR_W-1:0];
  assign occupancy        = tail_q - head_q;
  assign full             = (head_idx == tail_idx) && (head_q[PTR_W] != tail_q[PTR_W]);
  assign head_valid       = (occupancy != '0) && valid_q[head_idx];
  assign head_address     = addr_mem[head_idx];
  assign head_id          = id_mem[head_idx];
  assign head_flush_match = flush_match[head_idx];

  // Find occupied, still-valid slots whose id matches the flush id
  always_comb begin
    occupied         = '0;
    flush_match      = '0;
    flush_slot_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied[i]      = {1'b0, PTR_W'(i) - head_idx} < occupancy;
      flush_match[i]   = flush && occupied[i] && valid_q[i] && (id_mem[i] == flush_id);
      flush_slot_count = flush_slot_count + {{PTR_W{1'b0}}, flush_match[i]};
    end
  end

  // Next valid bits: flush clears matches, pop frees the head, push fills the tail
  always_comb begin
    valid_d = valid_q & ~flush_match;
    if (pop) begin
      valid_d[head_idx] = 1'b0;
    end
    if (push) begin
      valid_d[tail_idx] = push_valid;
    end
  end

  // Pointers and valid bits, cleared by reset so any queued work is discarded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (pop) begin
        head_q <= head_q + (PTR_W+1)'(1);
      end
      if (push) begin
        tail_q <= tail_q + (PTR_W+1)'(1);
      end
    end
  end

  // Payload storage needs no reset: it is only read behind a set valid bit
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_idx] <= push_address;
      id_mem[tail_idx]   <= push_id;
    end
  end

endmodule

// File: rtl/stall_consumer.sv
// stall_consumer: receiving end of an address/id/valid request channel.
// Requests are buffered, then retired one at a time after SERVICE_CYCLES
// cycles at the head. A flush drops every buffered or arriving request
// with a matching id. Define CONSUMER_STATS_EN to add saturating
// retired/flushed counters (stat_retired, stat_flushed).
module stall_consumer
  import stall_consumer_pkg::*;
#(
  parameter int DEPTH          = CONSUMER_DEPTH_DEFAULT,
  parameter int SERVICE_CYCLES = CONSUMER_SVC_DEFAULT,
  localparam int PTR_W         = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] in_address,
  input  logic [ID_WIDTH-1:0]      in_id,
  input  logic                     in_valid,
  output logic                     stall,
  input  logic                     flush,
  input  logic [ID_WIDTH-1:0]      flush_id,
  output logic                     ret_valid,
  output logic [ADDRESS_WIDTH-1:0] ret_address,
  output logic [ID_WIDTH-1:0]      ret_id,
  output logic                     flush_hit,
  output logic [PTR_W:0]           occupancy
`ifdef CONSUMER_STATS_EN
  ,
  output logic [15:0]              stat_retired,
  output logic [15:0]              stat_flushed
`endif
);

  localparam int SVC_W = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;
  localparam logic [SVC_W-1:0] SVC_RELOAD = SVC_W'(SERVICE_CYCLES - 1);

  logic [SVC_W-1:0]         svc_cnt;
  logic                     full;
  logic                     accept;
  logic                     incoming_match;
  logic                     incoming_drop;
  logic                     pop;
  logic                     retire;
  logic                     head_valid;
  logic                     head_flush_match;
  logic [ADDRESS_WIDTH-1:0] head_address;
  logic [ID_WIDTH-1:0]      head_id;
  logic [PTR_W:0]           flush_slot_count;
  head_action_e             head_action;

  // stall comes only from registered pointers, so a pop on a full edge
  // cannot open a slot for a push on that same edge
  assign stall          = full;
  assign accept         = in_valid && !full;
  assign incoming_match = flush && (in_id == flush_id);
  assign incoming_drop  = accept && incoming_match;

  consumer_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk              (clk),
    .reset            (reset),
    .push             (accept),
    .push_address     (in_address),
    .push_id          (in_id),
    .push_valid       (!incoming_match),
    .pop              (pop),
    .flush            (flush),
    .flush_id         (flush_id),
    .head_valid       (head_valid),
    .head_address     (head_address),
    .head_id          (head_id),
    .head_flush_match (head_flush_match),
    .flush_slot_count (flush_slot_count),
    .occupancy        (occupancy),
    .full             (full)
  );

  // Decide the head slot's fate; a flush on the retire edge turns it into a silent drop
  always_comb begin
    head_action = HEAD_EMPTY;
    if (occupancy != '0) begin
      if (!head_valid) begin
        head_action = HEAD_DROP;
      end else if (svc_cnt != '0) begin
        head_action = HEAD_WAIT;
      end else if (head_flush_match) begin
        head_action = HEAD_DROP;
      end else begin
        head_action = HEAD_RETIRE;
      end
    end
  end

  assign pop    = (head_action == HEAD_DROP) || (head_action == HEAD_RETIRE);
  assign retire = (head_action == HEAD_RETIRE);

  // Service counter counts down only while a valid head waits, otherwise reloads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      svc_cnt <= SVC_RELOAD;
    end else if (head_action == HEAD_WAIT) begin
      svc_cnt <= svc_cnt - SVC_W'(1);
    end else begin
      svc_cnt <= SVC_RELOAD;
    end
  end

  // Registered retire pulse with zeroed payload when idle, plus the flush_hit pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret_valid   <= 1'b0;
      ret_address <= '0;
      ret_id      <= '0;
      flush_hit   <= 1'b0;
    end else begin
      ret_valid   <= retire;
      ret_address <= retire ? head_address : '0;
      ret_id      <= retire ? head_id : '0;
      flush_hit   <= (flush_slot_count != '0) || incoming_drop;
    end
  end

`ifdef CONSUMER_STATS_EN
  logic [15:0] flushed_now;
  assign flushed_now = 16'(flush_slot_count) + 16'(incoming_drop);

  // Saturating counters of retired requests and of requests dropped by flushes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_retired <= '0;
      stat_flushed <= '0;
    end else begin
      if (retire) begin
        stat_retired <= sat_add16(stat_retired, 16'd1);
      end
      stat_flushed <= sat_add16(stat_flushed, flushed_now);
    end
  end
`endif

endmodule

// File: tb/tb_stall_consumer.sv
// Bench for stall_consumer: transaction-level model (list of pending
// requests with an "became head at edge N" timestamp) compared against
// the DUT every cycle, plus directed scenarios with literal expectations.
module tb_stall_consumer;
  import stall_consumer_pkg::*;

  localparam int DEPTH = 4;
  localparam int SVC   = 3;
  localparam int PTR_W = 2;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [ADDRESS_WIDTH-1:0] in_address = '0;
  logic [ID_WIDTH-1:0]      in_id = '0;
  logic                     in_valid = 1'b0;
  logic                     stall;
  logic                     flush = 1'b0;
  logic [ID_WIDTH-1:0]      flush_id = '0;
  logic                     ret_valid;
  logic [ADDRESS_WIDTH-1:0] ret_address;
  logic [ID_WIDTH-1:0]      ret_id;
  logic                     flush_hit;
  logic [PTR_W:0]           occupancy;
`ifdef CONSUMER_STATS_EN
  logic [15:0]              stat_retired;
  logic [15:0]              stat_flushed;
`endif

  stall_consumer #(
    .DEPTH          (DEPTH),
    .SERVICE_CYCLES (SVC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_address  (in_address),
    .in_id       (in_id),
    .in_valid    (in_valid),
    .stall       (stall),
    .flush       (flush),
    .flush_id    (flush_id),
    .ret_valid   (ret_valid),
    .ret_address (ret_address),
    .ret_id      (ret_id),
    .flush_hit   (flush_hit),
    .occupancy   (occupancy)
`ifdef CONSUMER_STATS_EN
    ,
    .stat_retired (stat_retired),
    .stat_flushed (stat_flushed)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  bit compare_en = 1'b1;

  typedef struct {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [ID_WIDTH-1:0]      id;
    bit                       alive;
  } entry_t;

  entry_t                   mq[$];
  int                       edge_cnt = 0;
  int                       head_since = 0;
  bit                       exp_ret_valid = 1'b0;
  logic [ADDRESS_WIDTH-1:0] exp_ret_addr = '0;
  logic [ID_WIDTH-1:0]      exp_ret_id = '0;
  bit                       exp_flush_hit = 1'b0;

  logic [ID_WIDTH-1:0]      ret_log[$];
  int                       ret_time[$];

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Model: a head entry retires SVC edges after it became head, unless flushed
  always @(posedge clk or negedge reset) begin : model
    int     n;
    bit     popped;
    bit     hit;
    bit     take;
    entry_t ent;
    if (!reset) begin
      mq.delete();
      head_since    = 0;
      exp_ret_valid = 1'b0;
      exp_ret_addr  = '0;
      exp_ret_id    = '0;
      exp_flush_hit = 1'b0;
    end else begin
      edge_cnt++;
      n             = mq.size();
      take          = in_valid && (n != DEPTH);
      popped        = 1'b0;
      hit           = 1'b0;
      exp_ret_valid = 1'b0;
      exp_ret_addr  = '0;
      exp_ret_id    = '0;
      if (n > 0) begin
        if (!mq[0].alive) begin
          popped = 1'b1;
        end else if (edge_cnt - head_since >= SVC) begin
          popped = 1'b1;
          if (!(flush && mq[0].id == flush_id)) begin
            exp_ret_valid = 1'b1;
            exp_ret_addr  = mq[0].addr;
            exp_ret_id    = mq[0].id;
          end
        end
      end
      if (flush) begin
        foreach (mq[i]) begin
          if (mq[i].alive && mq[i].id == flush_id) begin
            mq[i].alive = 1'b0;
            hit = 1'b1;
          end
        end
      end
      if (popped) begin
        void'(mq.pop_front());
      end
      if (take) begin
        ent.addr  = in_address;
        ent.id    = in_id;
        ent.alive = !(flush && in_id == flush_id);
        if (!ent.alive) begin
          hit = 1'b1;
        end
        mq.push_back(ent);
      end
      if ((popped || n == 0) && mq.size() > 0) begin
        head_since = edge_cnt;
      end
      exp_flush_hit = hit;
    end
  end

  // Compare every DUT output against the model once per cycle
  always @(negedge clk) begin
    if (compare_en) begin
      check_output("ret_valid", 64'(ret_valid), 64'(exp_ret_valid));
      check_output("ret_address", 64'(ret_address), 64'(exp_ret_addr));
      check_output("ret_id", 64'(ret_id), 64'(exp_ret_id));
      check_output("flush_hit", 64'(flush_hit), 64'(exp_flush_hit));
      check_output("occupancy", 64'(occupancy), 64'(mq.size()));
      check_output("stall", 64'(stall), 64'(mq.size() == DEPTH));
    end
  end

  // Log of retired ids and the edge each retire was reported after
  always @(negedge clk) begin
    if (ret_valid) begin
      ret_log.push_back(ret_id);
      ret_time.push_back(edge_cnt);
    end
  end

  function automatic logic [63:0] log_at(input int idx);
    return (idx < ret_log.size()) ? 64'(ret_log[idx]) : 64'hDEAD;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input bit v, input logic [ADDRESS_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] id,
                                input bit f, input logic [ID_WIDTH-1:0] fid);
    in_valid   = v;
    in_address = a;
    in_id      = id;
    flush      = f;
    flush_id   = fid;
    tick(1);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && occupancy != '0; k++) begin
      tick(1);
    end
    check_output("drain_empty", 64'(occupancy), 64'd0);
    tick(2);
  endtask

  initial begin
    int base;
    int sent;
    bit taken;
    bit stall_seen;

    tick(2);
    check_output("reset_occupancy", 64'(occupancy), 64'd0);
    check_output("reset_stall", 64'(stall), 64'd0);
    reset = 1'b1;
    tick(1);

    // Single request, latency SERVICE_CYCLES edges after accept
    base = ret_log.size();
    apply_stimulus(1'b1, 32'h04, 8'h11, 1'b0, 8'h00);
    in_valid = 1'b0;
    check_output("t1_occ_after_accept", 64'(occupancy), 64'd1);
    tick(2);
    check_output("t1_early_ret", 64'(ret_valid), 64'd0);
    tick(1);
    check_output("t1_ret_valid", 64'(ret_valid), 64'd1);
    check_output("t1_ret_address", 64'(ret_address), 64'h04);
    check_output("t1_ret_id", 64'(ret_id), 64'h11);
    check_output("t1_occ_after", 64'(occupancy), 64'd0);
    tick(1);
    check_output("t1_ret_idle", 64'(ret_valid), 64'd0);
    check_output("t1_addr_idle", 64'(ret_address), 64'd0);
    tick(1);

    // Continuous producer, ids 0x21..0x26, held while stalled
    base = ret_log.size();
    sent = 0;
    stall_seen = 1'b0;
    for (int k = 0; k < 40 && sent < 6; k++) begin
      in_valid   = 1'b1;
      in_id      = ID_WIDTH'(8'h21 + sent);
      in_address = ADDRESS_WIDTH'(32'h100 + sent);
      taken      = !stall;
      if (stall) stall_seen = 1'b1;
      tick(1);
      if (taken) sent++;
    end
    in_valid = 1'b0;
    check_output("t2_all_sent", 64'(sent), 64'd6);
    check_output("t2_stall_seen", 64'(stall_seen), 64'd1);
    drain(40);
    check_output("t2_count", 64'(ret_log.size() - base), 64'd6);
    for (int i = 0; i < 6; i++) begin
      check_output($sformatf("t2_order_%0d", i), log_at(base + i), 64'(8'h21 + i));
    end
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("t2_spacing_%0d", i),
                   (base + i + 1 < ret_time.size()) ? 64'(ret_time[base+i+1] - ret_time[base+i]) : 64'hDEAD,
                   64'd3);
    end

    // Flush the middle of three buffered requests
    base = ret_log.size();
    apply_stimulus(1'b1, 32'h200, 8'h15, 1'b0, 8'h00);
    apply_stimulus(1'b1, 32'h201, 8'h16, 1'b0, 8'h00);
    apply_stimulus(1'b1, 32'h202, 8'h17, 1'b0, 8'h00);
    check_output("t3_occ_buffered", 64'(occupancy), 64'd3);
    apply_stimulus(1'b0, 32'h0, 8'h00, 1'b1, 8'h16);
    flush = 1'b0;
    check_output("t3_flush_hit", 64'(flush_hit), 64'd1);
    check_output("t3_first_ret", 64'(ret_id), 64'h15);
    drain(20);
    check_output("t3_count", 64'(ret_log.size() - base), 64'd2);
    check_output("t3_ret0", log_at(base), 64'h15);
    check_output("t3_ret1", log_at(base + 1), 64'h17);

    // Flush matching an incoming request on its accept edge
    base = ret_log.size();
    check_output("t4_no_stall", 64'(stall), 64'd0);
    apply_stimulus(1'b1, 32'h300, 8'h16, 1'b1, 8'h16);
    in_valid = 1'b0;
    flush    = 1'b0;
    check_output("t4_taken", 64'(occupancy), 64'd1);
    check_output("t4_flush_hit", 64'(flush_hit), 64'd1);
    tick(6);
    check_output("t4_never_retired", 64'(ret_log.size() - base), 64'd0);
    check_output("t4_occ", 64'(occupancy), 64'd0);

    // Flush matching the head on its retire edge
    base = ret_log.size();
    apply_stimulus(1'b1, 32'h400, 8'h31, 1'b0, 8'h00);
    apply_stimulus(1'b1, 32'h401, 8'h32, 1'b0, 8'h00);
    apply_stimulus(1'b0, 32'h0, 8'h00, 1'b0, 8'h00);
    apply_stimulus(1'b0, 32'h0, 8'h00, 1'b1, 8'h31);
    flush = 1'b0;
    check_output("t5_suppressed", 64'(ret_valid), 64'd0);
    check_output("t5_flush_hit", 64'(flush_hit), 64'd1);
    tick(2);
    check_output("t5_not_yet", 64'(ret_valid), 64'd0);
    tick(1);
    check_output("t5_next_ret", 64'(ret_valid), 64'd1);
    check_output("t5_next_id", 64'(ret_id), 64'h32);
    drain(10);
    check_output("t5_count", 64'(ret_log.size() - base), 64'd1);

    // Reset with three entries queued
    apply_stimulus(1'b1, 32'h500, 8'h41, 1'b0, 8'h00);
    apply_stimulus(1'b1, 32'h501, 8'h42, 1'b0, 8'h00);
    apply_stimulus(1'b1, 32'h502, 8'h43, 1'b0, 8'h00);
    in_valid = 1'b0;
    check_output("t6_occ_before", 64'(occupancy), 64'd3);
    #2 reset = 1'b0;
    #1;
    check_output("t6_occ_reset", 64'(occupancy), 64'd0);
    check_output("t6_stall_reset", 64'(stall), 64'd0);
    check_output("t6_ret_reset", 64'(ret_valid), 64'd0);
    tick(2);
    reset = 1'b1;
    base = ret_log.size();
`ifdef CONSUMER_STATS_EN
    check_output("t6_stat_retired", 64'(stat_retired), 64'd0);
    check_output("t6_stat_flushed", 64'(stat_flushed), 64'd0);
`endif
    tick(8);
    check_output("t6_no_stale_retire", 64'(ret_log.size() - base), 64'd0);
    check_output("t6_occ_after", 64'(occupancy), 64'd0);

    compare_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
